// File: rtl/cla_arb_pkg.sv
// Shared definitions for the round-robin arbiter in front of the shared CLA adder.
//   - arb_state_e : arbiter FSM states
//   - DefWidth/DefNreq : default operand width and requester count
//   - rr_pick()   : round-robin winner search starting at a pointer
package cla_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam int unsigned DefWidth = 42;
  localparam int unsigned DefNreq  = 4;
  // rr_pick works on vectors sized for the largest supported requester count.
  localparam int unsigned MaxReq   = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid scanning ptr, ptr+1, ... modulo nreq.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] valid,
                                       input logic [2:0]        ptr,
                                       input int unsigned       nreq);
    rr_pick_t    res;
    int unsigned k;
    res = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < nreq && !res.found) begin
        // ptr < nreq and i < nreq, so one subtraction is enough for the wrap.
        k = 32'(ptr) + i;
        if (k >= nreq) k = k - nreq;
        if (valid[k]) begin
          res.found = 1'b1;
          res.idx   = 3'(k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cla_42bit.sv
// Carry-lookahead adder (parallel-prefix carry network).
//   a_i, b_i : operands
//   cin_i    : carry-in
//   sum_o    : WIDTH-bit sum
//   cout_o   : carry-out
module cla_42bit #(
  parameter int unsigned WIDTH = 42
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // Bit 0 of the extended vectors carries cin as a pure generate term.
  localparam int unsigned N      = WIDTH + 1;
  localparam int unsigned Levels = $clog2(N);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N-1:0] half;

  always_comb begin
    half = {a_i ^ b_i, 1'b0};
    gen  = {a_i & b_i, cin_i};
    prop = half;
    // After the loop gen[i] is the carry out of extended bit i.
    for (int unsigned s = 0; s < Levels; s++) begin
      gen  = gen | (prop & (gen << (1 << s)));
      prop = prop & (prop << (1 << s));
    end
  end

  assign sum_o  = half[N-1:1] ^ gen[N-2:0];
  assign cout_o = gen[N-1];

endmodule

// File: rtl/cla_rr_arbiter.sv
// Round-robin arbiter sharing one cla_42bit adder between NREQ requesters.
// Operands are registered ahead of the adder and the WIDTH+1 bit sum after it;
// one transaction takes IDLE -> EXEC -> RESP -> IDLE (minimum 3 cycles).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_req_valid    : per-requester operand valid
//   i_req_add1/2   : flattened operands, requester k at [k*WIDTH +: WIDTH]
//   o_req_ready    : per-requester accept (at most one high, IDLE only)
//   o_rsp_valid    : one-hot response valid to the owning requester
//   o_rsp_result   : registered sum, MSB is the carry-out
//   o_rsp_id       : owner of the current response
//   i_rsp_ready    : shared response accept
//   o_busy         : state is not IDLE
module cla_rr_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int unsigned WIDTH = DefWidth,
  parameter  int unsigned NREQ  = DefNreq,
  localparam int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_add1,
  input  logic [NREQ*WIDTH-1:0] i_req_add2,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [NREQ-1:0]      o_rsp_valid,
  output logic [WIDTH:0]       o_rsp_result,
  output logic [IDW-1:0]       o_rsp_id,
  input  logic                 i_rsp_ready,
  output logic                 o_busy
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [WIDTH:0]   result_q, result_d;

  logic [MaxReq-1:0] valid_ext;
  rr_pick_t          pick;
  logic [IDW-1:0]    win;
  logic              accept;
  logic [WIDTH-1:0]  sum;
  logic              cout;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = i_req_valid;
  end

  assign pick = rr_pick(valid_ext, 3'(ptr_q), NREQ);
  assign win  = IDW'(pick.idx);

  // Ready is held low while reset is asserted so nothing is accepted then.
  always_comb begin
    o_req_ready = '0;
    if (i_rst_n && state_q == StIdle && pick.found) o_req_ready[win] = 1'b1;
  end

  assign accept = |(o_req_ready & i_req_valid);

  cla_42bit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (op1_q),
    .b_i    (op2_q),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          op1_d   = i_req_add1[win*WIDTH +: WIDTH];
          op2_d   = i_req_add2[win*WIDTH +: WIDTH];
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d = {cout, sum};
        state_d  = StResp;
      end
      StResp: begin
        if (i_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      id_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (state_q == StResp) o_rsp_valid[id_q] = 1'b1;
  end

  assign o_rsp_result = result_q;
  assign o_rsp_id     = id_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// Self-checking bench for cla_rr_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_cla_rr_arbiter;

  localparam int W = 42;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   v;
  logic [N*W-1:0] a1, a2;
  logic           rr;
  logic [N-1:0]   ready, rsp_valid;
  logic [W:0]     res;
  logic [1:0]     rid;
  logic           busy;

  always #5 clk = ~clk;

  cla_rr_arbiter #(
    .WIDTH (W),
    .NREQ  (N)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (v),
    .i_req_add1   (a1),
    .i_req_add2   (a2),
    .o_req_ready  (ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_result (res),
    .o_rsp_id     (rid),
    .i_rsp_ready  (rr),
    .o_busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 = free, 1 = computing, 2 = response outstanding.
  int         m_phase = 0;
  int         m_ptr = 0;
  int         m_id = 0;
  int         m_win = 0;
  bit         m_found = 0;
  logic [W:0] m_res = '0;
  logic [N-1:0] exp_ready, exp_rsp_valid;

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic model_eval();
    m_found = 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (!m_found && v[k]) begin
        m_found = 1;
        m_win   = k;
      end
    end
    exp_ready = '0;
    if (rst_n && m_phase == 0 && m_found) exp_ready[m_win] = 1'b1;
    exp_rsp_valid = '0;
    if (m_phase == 2) exp_rsp_valid[m_id] = 1'b1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_eval();
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 0;
      m_id    = 0;
      m_res   = '0;
    end else if (m_phase == 0) begin
      if (m_found) begin
        m_id    = m_win;
        m_res   = {1'b0, a1[m_win*W +: W]} + {1'b0, a2[m_win*W +: W]};
        m_ptr   = (m_win + 1) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (rr) begin
      m_phase = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v     = '0;
    rr    = 1'b0;
    settle();
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v     = '1;
    rr    = 1'b0;
    for (int k = 0; k < N; k++) begin
      a1[k*W +: W] = rnd_op();
      a2[k*W +: W] = rnd_op();
    end
    settle();
    tick();
    tick();
    settle();
    n_cmp++; if (ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", ready); end
    n_cmp++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (res !== 43'h0) begin n_err++; $display("FAIL reset_result: got %h want 0", res); end
    n_cmp++; if (rid !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", rid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    v     = '0;
    settle();
    n_cmp++; if (ready !== 4'b0) begin n_err++; $display("FAIL idle_no_valid_ready: got %b want 0000", ready); end
  endtask

  task automatic test_carry_ripple();
    v  = 4'b0001;
    rr = 1'b1;
    a1[0 +: W] = 42'h3FF_FFFF_FFFF;
    a2[0 +: W] = 42'h1;
    settle();
    n_cmp++; if (ready !== 4'b0001) begin n_err++; $display("FAIL ripple_grant: got %b want 0001", ready); end
    tick();
    v = '0;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL ripple_exec: rsp_valid %b busy %b want 0000 1", rsp_valid, busy);
    end
    tick();
    settle();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL ripple_rsp_valid: got %b want 0001", rsp_valid); end
    n_cmp++; if (res !== 43'h400_0000_0000) begin n_err++; $display("FAIL ripple_result: got %h want 40000000000", res); end
    n_cmp++; if (rid !== 2'd0) begin n_err++; $display("FAIL ripple_id: got %0d want 0", rid); end
    tick();
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ripple_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_fairness();
    int grants[$];
    int results[$];
    int acc_cyc[$];
    int exp_g[5];
    int exp_r[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_r = '{0, 2, 4, 6, 0};
    do_reset();
    v  = '1;
    rr = 1'b1;
    for (int k = 0; k < N; k++) begin
      a1[k*W +: W] = W'(k);
      a2[k*W +: W] = W'(k);
    end
    for (int cyc = 0; cyc < 15; cyc++) begin
      settle();
      n_cmp++; if (ready !== exp_ready) begin n_err++; $display("FAIL fair_ready c%0d: got %b want %b", cyc, ready, exp_ready); end
      n_cmp++; if (rsp_valid !== exp_rsp_valid) begin
        n_err++; $display("FAIL fair_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, exp_rsp_valid);
      end
      for (int k = 0; k < N; k++) if (ready[k] === 1'b1) begin grants.push_back(k); acc_cyc.push_back(cyc); end
      if (rsp_valid !== 4'b0) results.push_back(int'(res));
      tick();
    end
    n_cmp++;
    if (grants.size() != 5 || results.size() != 5) begin
      n_err++; $display("FAIL fair_counts: grants %0d results %0d want 5 5", grants.size(), results.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++; if (grants[i] != exp_g[i]) begin n_err++; $display("FAIL fair_order[%0d]: got %0d want %0d", i, grants[i], exp_g[i]); end
        n_cmp++; if (results[i] != exp_r[i]) begin n_err++; $display("FAIL fair_result[%0d]: got %0d want %0d", i, results[i], exp_r[i]); end
        n_cmp++; if (acc_cyc[i] != 3 * i) begin n_err++; $display("FAIL fair_spacing[%0d]: got cycle %0d want %0d", i, acc_cyc[i], 3 * i); end
      end
    end
    v = '0;
    settle();
    tick();
    tick();
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    rr = 1'b1;
    v  = 4'b0100;
    settle();
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("FAIL wrap_grant2: got %b want 0100", ready); end
    tick();
    v = '0;
    tick();
    tick();
    v = 4'b0010;
    settle();
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL wrap_grant1: got %b want 0010", ready); end
    tick();
    v = '0;
    tick();
    tick();
    v = 4'b1111;
    settle();
    n_cmp++; if (ready !== 4'b0100) begin n_err++; $display("FAIL wrap_ptr2: got %b want 0100", ready); end
    v = '0;
    settle();
  endtask

  task automatic test_backpressure();
    do_reset();
    v  = 4'b1111;
    rr = 1'b0;
    for (int k = 1; k < N; k++) begin
      a1[k*W +: W] = rnd_op();
      a2[k*W +: W] = rnd_op();
    end
    a1[0 +: W] = 42'h155_5555_5555;
    a2[0 +: W] = 42'h2AA_AAAA_AAAA;
    settle();
    n_cmp++; if (ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant: got %b want 0001", ready); end
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      n_cmp++; if (rsp_valid !== 4'b0001 || res !== 43'h3FF_FFFF_FFFF) begin
        n_err++; $display("FAIL bp_hold[%0d]: rsp_valid %b result %h want 0001 3ffffffffff", i, rsp_valid, res);
      end
      n_cmp++; if (ready !== 4'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready); end
      tick();
    end
    rr = 1'b1;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL bp_before_hs: got %b want 0001", rsp_valid); end
    tick();
    settle();
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got %b want 0010", ready); end
    tick();
    v = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    v  = 4'b0100;
    rr = 1'b1;
    a1[2*W +: W] = rnd_op();
    a2[2*W +: W] = rnd_op();
    settle();
    tick();
    rst_n = 1'b0;
    v     = '0;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_in_exec: busy got %b want 1", busy); end
    tick();
    rst_n = 1'b1;
    settle();
    n_cmp++; if (rsp_valid !== 4'b0 || busy !== 1'b0 || res !== 43'h0 || rid !== 2'd0 || ready !== 4'b0) begin
      n_err++; $display("FAIL mid_cleared: rsp_valid %b busy %b result %h id %0d ready %b want all 0",
                        rsp_valid, busy, res, rid, ready);
    end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      if (rsp_valid !== 4'b0) seen = 1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL mid_no_response: got a response pulse want none"); end
    v = 4'b1010;
    settle();
    n_cmp++; if (ready !== 4'b0010) begin n_err++; $display("FAIL mid_lowest_grant: got %b want 0010", ready); end
    tick();
    v = '0;
    tick();
    tick();
  endtask

  task automatic test_withdrawal();
    bit seen3;
    do_reset();
    v  = 4'b0001;
    rr = 1'b0;
    settle();
    tick();
    v = '0;
    tick();
    v = 4'b1000;
    settle();
    n_cmp++; if (ready !== 4'b0) begin n_err++; $display("FAIL wd_ready_in_resp: got %b want 0000", ready); end
    tick();
    v  = '0;
    rr = 1'b1;
    seen3 = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      n_cmp++; if (rsp_valid !== exp_rsp_valid) begin
        n_err++; $display("FAIL wd_rsp_valid[%0d]: got %b want %b", i, rsp_valid, exp_rsp_valid);
      end
      if (ready[3] === 1'b1 || rsp_valid[3] === 1'b1) seen3 = 1;
      tick();
    end
    n_cmp++; if (seen3) begin n_err++; $display("FAIL wd_req3: requester 3 served, want never"); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      v     = N'($urandom());
      rr    = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) begin
        a1[k*W +: W] = rnd_op();
        a2[k*W +: W] = rnd_op();
      end
      settle();
      n_cmp++; if (ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, ready, exp_ready); end
      n_cmp++; if (rsp_valid !== exp_rsp_valid) begin
        n_err++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, rsp_valid, exp_rsp_valid);
      end
      n_cmp++; if (busy !== (m_phase != 0)) begin n_err++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, m_phase != 0); end
      if (m_phase == 2) begin
        n_cmp++; if (res !== m_res || rid !== 2'(m_id)) begin
          n_err++; $display("FAIL rnd_rsp c%0d: result %h id %0d want %h %0d", cyc, res, rid, m_res, m_id);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v     = '0;
    a1    = '0;
    a2    = '0;
    rr    = 1'b0;
    test_reset();
    test_carry_ripple();
    test_fairness();
    test_pointer_wrap();
    test_backpressure();
    test_reset_mid();
    test_withdrawal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
